seq_clock_set_ctrl: RTL and testbench

User-interface controller that sequences the 12-hour clock counter, which takes tick, set_en, set_hours, set_mins and set_pm inputs.
- Divides the system clock into minute ticks.
- Runs an edit FSM driven by two pre-debounced single-cycle button pulses (mode, inc).
- Lets the user step through hours, then minutes, then AM/PM, and commits the new time with a one-cycle set_en pulse.
- Suppresses ticks while editing and abandons an edit after an inactivity timeout.

---
 rtl/seq_clock_set_ctrl.sv | 135 +++++++++++++
 tb/tb_seq_clock_set_ctrl.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/seq_clock_set_ctrl.sv
// seq_clock_set_ctrl: minute-tick prescaler plus time-edit FSM for a 12-hour clock counter.
// Walks the user through hours, minutes and AM/PM, then loads the edited time with set_en.
module seq_clock_set_ctrl #(
  parameter int unsigned TICK_DIV     = 4,
  parameter int unsigned EDIT_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic [3:0] cur_hours,
  input  logic [5:0] cur_mins,
  input  logic       cur_pm,
  output logic       tick,
  output logic       set_en,
  output logic [3:0] set_hours,
  output logic [5:0] set_mins,
  output logic       set_pm,
  output logic [1:0] edit_field
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned TW = (EDIT_TIMEOUT > 1) ? $clog2(EDIT_TIMEOUT) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [TW-1:0] TMO_MAX   = TW'(EDIT_TIMEOUT - 1);

  typedef enum logic [2:0] {
    RUN      = 3'd0,
    EDIT_HR  = 3'd1,
    EDIT_MIN = 3'd2,
    EDIT_PM  = 3'd3,
    COMMIT   = 3'd4
  } state_t;

  state_t        state;
  logic [PW-1:0] presc;
  logic [TW-1:0] tmo;
  logic [3:0]    hours_q;
  logic [5:0]    mins_q;
  logic          pm_q;

  // Edit FSM, tick prescaler, inactivity timer and edit registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= RUN;
      presc   <= '0;
      tmo     <= '0;
      hours_q <= 4'd12;
      mins_q  <= 6'd0;
      pm_q    <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          tmo <= '0;
          if (btn_mode) begin
            hours_q <= cur_hours;
            mins_q  <= cur_mins;
            pm_q    <= cur_pm;
            presc   <= '0;
            state   <= EDIT_HR;
          end else if (presc == PRESC_MAX) begin
            presc <= '0;
          end else begin
            presc <= presc + PW'(1);
          end
        end

        EDIT_HR, EDIT_MIN, EDIT_PM: begin
          presc <= '0;
          // Any button activity restarts the inactivity window
          if (btn_mode || btn_inc) begin
            tmo <= '0;
          end else if (tmo == TMO_MAX) begin
            tmo   <= '0;
            state <= RUN;
          end else begin
            tmo <= tmo + TW'(1);
          end

          // Mode takes priority; a simultaneous inc is dropped
          if (btn_mode) begin
            case (state)
              EDIT_HR:  state <= EDIT_MIN;
              EDIT_MIN: state <= EDIT_PM;
              default:  state <= COMMIT;
            endcase
          end else if (btn_inc) begin
            case (state)
              EDIT_HR: begin
                if (hours_q == 4'd0 || hours_q >= 4'd12) hours_q <= 4'd1;
                else                                     hours_q <= hours_q + 4'd1;
              end
              EDIT_MIN: begin
                if (mins_q >= 6'd59) mins_q <= 6'd0;
                else                 mins_q <= mins_q + 6'd1;
              end
              default: pm_q <= ~pm_q;
            endcase
          end
        end

        COMMIT: begin
          presc <= '0;
          tmo   <= '0;
          state <= RUN;
        end

        default: begin
          presc <= '0;
          tmo   <= '0;
          state <= RUN;
        end
      endcase
    end
  end

  // Strobes decoded straight from registered state
  assign tick      = (state == RUN) && (presc == PRESC_MAX);
  assign set_en    = (state == COMMIT);
  assign set_hours = hours_q;
  assign set_mins  = mins_q;
  assign set_pm    = pm_q;

  // Field indicator for the display
  always_comb begin
    edit_field = 2'd0;
    case (state)
      EDIT_HR:  edit_field = 2'd1;
      EDIT_MIN: edit_field = 2'd2;
      EDIT_PM:  edit_field = 2'd3;
      default:  edit_field = 2'd0;
    endcase
  end

endmodule

// File: tb/tb_seq_clock_set_ctrl.sv
// Bench for seq_clock_set_ctrl: the driver pushes the expected output word for each cycle,
// an independent monitor pops and compares on the falling edge.
module tb_seq_clock_set_ctrl;

  typedef struct packed {
    logic       tick;
    logic       set_en;
    logic [1:0] field;
    logic [3:0] hours;
    logic [5:0] mins;
    logic       pm;
  } obs_t;

  logic       clk;
  logic       reset;
  logic       btn_mode;
  logic       btn_inc;
  logic [3:0] cur_hours;
  logic [5:0] cur_mins;
  logic       cur_pm;
  logic       tick;
  logic       set_en;
  logic [3:0] set_hours;
  logic [5:0] set_mins;
  logic       set_pm;
  logic [1:0] edit_field;

  obs_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_pushed = 0;
  int   n_popped = 0;

  seq_clock_set_ctrl #(.TICK_DIV(4), .EDIT_TIMEOUT(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .btn_mode   (btn_mode),
    .btn_inc    (btn_inc),
    .cur_hours  (cur_hours),
    .cur_mins   (cur_mins),
    .cur_pm     (cur_pm),
    .tick       (tick),
    .set_en     (set_en),
    .set_hours  (set_hours),
    .set_mins   (set_mins),
    .set_pm     (set_pm),
    .edit_field (edit_field)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic obs_t mk(input logic t, input logic s, input logic [1:0] f,
                              input logic [3:0] h, input logic [5:0] m, input logic p);
    obs_t o;
    o.tick = t; o.set_en = s; o.field = f; o.hours = h; o.mins = m; o.pm = p;
    return o;
  endfunction

  // One cycle: drive buttons for the next edge, expect the outputs visible during this cycle
  task automatic cyc(input logic m, input logic i, input logic t, input logic s,
                     input logic [1:0] f, input logic [3:0] h, input logic [5:0] mn,
                     input logic p);
    @(posedge clk);
    #1;
    btn_mode = m;
    btn_inc  = i;
    exp_q.push_back(mk(t, s, f, h, mn, p));
    n_pushed++;
  endtask

  // Monitor / scoreboard
  initial begin
    obs_t e;
    obs_t a;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_popped++;
        a = mk(tick, set_en, edit_field, set_hours, set_mins, set_pm);
        n_checks++;
        if (a !== e) begin
          n_fail++;
          $display("FAIL obs#%0d t=%0t: got tick=%b set_en=%b field=%0d %0d:%0d pm=%b, expected tick=%b set_en=%b field=%0d %0d:%0d pm=%b",
                   n_popped, $time, a.tick, a.set_en, a.field, a.hours, a.mins, a.pm,
                   e.tick, e.set_en, e.field, e.hours, e.mins, e.pm);
        end
      end
    end
  end

  initial begin
    reset = 1'b1; btn_mode = 1'b0; btn_inc = 1'b0;
    cur_hours = 4'd11; cur_mins = 6'd58; cur_pm = 1'b0;

    // Reset held, then released mid-cycle (this cycle is run cycle 0)
    cyc(0, 0, 0, 0, 0, 12, 0, 0);
    @(posedge clk); #1;
    exp_q.push_back(mk(0, 0, 0, 12, 0, 0)); n_pushed++;
    #2 reset = 1'b0;
    // Idle run: tick on cycles 3, 7, 11
    for (int k = 1; k <= 11; k++) cyc(0, 0, ((k % 4) == 3), 0, 0, 12, 0, 0);

    // Full edit from 11:58 AM
    cyc(1, 0, 0, 0, 0, 12, 0, 0);
    cyc(0, 1, 0, 0, 1, 11, 58, 0);
    cyc(0, 1, 0, 0, 1, 12, 58, 0);
    cyc(1, 0, 0, 0, 1, 1, 58, 0);
    cyc(0, 1, 0, 0, 2, 1, 58, 0);
    cyc(0, 1, 0, 0, 2, 1, 59, 0);
    cyc(0, 1, 0, 0, 2, 1, 0, 0);
    cyc(1, 0, 0, 0, 2, 1, 1, 0);
    cyc(0, 1, 0, 0, 3, 1, 1, 0);
    cyc(1, 0, 0, 0, 3, 1, 1, 1);
    cyc(0, 0, 0, 1, 0, 1, 1, 1);   // commit
    cyc(0, 0, 0, 0, 0, 1, 1, 1);
    cyc(0, 0, 0, 0, 0, 1, 1, 1);
    cyc(0, 0, 0, 0, 0, 1, 1, 1);
    cyc(0, 0, 1, 0, 0, 1, 1, 1);   // 4 cycles after commit

    // Timeout: enter, one inc, then 16 idle cycles in EDIT_HR
    cyc(1, 0, 0, 0, 0, 1, 1, 1);
    cyc(0, 1, 0, 0, 1, 11, 58, 0);
    for (int k = 0; k < 16; k++) cyc(0, 0, 0, 0, 1, 12, 58, 0);
    for (int k = 0; k < 8; k++) cyc(0, 0, ((k % 4) == 3), 0, 0, 12, 58, 0);

    // inc ignored in RUN; mode on a tick cycle still ticks
    cur_hours = 4'd5; cur_mins = 6'd10; cur_pm = 1'b1;
    cyc(0, 1, 0, 0, 0, 12, 58, 0);
    cyc(0, 0, 0, 0, 0, 12, 58, 0);
    cyc(0, 0, 0, 0, 0, 12, 58, 0);
    cyc(1, 0, 1, 0, 0, 12, 58, 0);
    // mode + inc together: advance, hours untouched
    cyc(1, 1, 0, 0, 1, 5, 10, 1);
    cyc(0, 0, 0, 0, 2, 5, 10, 1);
    cyc(1, 0, 0, 0, 2, 5, 10, 1);
    cyc(1, 0, 0, 0, 3, 5, 10, 1);
    cyc(1, 1, 0, 1, 0, 5, 10, 1);  // buttons in COMMIT ignored
    // Out-of-range capture 0:63
    cur_hours = 4'd0; cur_mins = 6'd63; cur_pm = 1'b0;
    cyc(1, 0, 0, 0, 0, 5, 10, 1);
    cyc(0, 1, 0, 0, 1, 0, 63, 0);
    cyc(1, 0, 0, 0, 1, 1, 63, 0);
    cyc(0, 1, 0, 0, 2, 1, 63, 0);
    cyc(0, 1, 0, 0, 2, 1, 0, 0);
    cyc(0, 0, 0, 0, 2, 1, 1, 0);

    // Async reset mid-cycle in EDIT_MIN, visible before the next edge
    @(posedge clk); #2;
    reset = 1'b1;
    exp_q.push_back(mk(0, 0, 0, 12, 0, 0)); n_pushed++;
    cyc(1, 0, 0, 0, 0, 12, 0, 0);   // mode ignored while in reset
    @(posedge clk); #1;
    btn_mode = 1'b0;
    exp_q.push_back(mk(0, 0, 0, 12, 0, 0)); n_pushed++;
    #2 reset = 1'b0;
    for (int k = 1; k <= 6; k++) cyc(0, 0, ((k % 4) == 3), 0, 0, 12, 0, 0);

    @(posedge clk); @(posedge clk);
    n_checks++;
    if (exp_q.size() != 0 || n_popped != n_pushed) begin
      n_fail++;
      $display("FAIL scoreboard_drain: popped %0d of %0d pushed", n_popped, n_pushed);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d checks done", n_checks);
    $fatal(1, "watchdog expired");
  end

endmodule
